// File: rtl/fe_pkg.sv
// Shared definitions for GF(2^255-19) field arithmetic blocks.
package fe_pkg;

    localparam int FE_BITS = 255;

    typedef logic [FE_BITS-1:0] fe_t;

    // p = 2^255 - 19
    localparam fe_t FE_P         = fe_t'((256'd1 << 255) - 256'd19);
    localparam fe_t FE_P_MINUS_2 = FE_P - fe_t'(2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        FIN   = 2'd3
    } feinv_state_t;

    typedef enum logic {
        OP_SQR = 1'b0,
        OP_MUL = 1'b1
    } feinv_op_t;

endpackage

// File: rtl/femul.sv
// Modular multiplier for GF(2^255-19): start/done handshake, two-cycle latency.
// Operands are captured on start; a new start discards any product in flight.
// The result is always canonical (0 .. p-1), so non-canonical inputs are reduced.
module femul
    import fe_pkg::*;
(
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [FE_BITS-1:0] i_a,
    input  logic [FE_BITS-1:0] i_b,
    output logic               o_done,
    output logic [FE_BITS-1:0] o_out
);

    localparam int PW  = 2 * FE_BITS;
    localparam int F1W = FE_BITS + 6;
    localparam int F2W = FE_BITS + 1;

    logic [FE_BITS-1:0] r_a;
    logic [FE_BITS-1:0] r_b;
    logic [FE_BITS-1:0] r_out;
    logic               r_busy;
    logic               r_done;

    logic [PW-1:0]      w_prod;
    logic [F1W-1:0]     w_fold1;
    logic [F2W-1:0]     w_fold2;
    logic [FE_BITS-1:0] w_fold3;
    logic [FE_BITS-1:0] w_red;

    // Product and reduction: 2^255 == 19 (mod p), so fold the high part down
    // three times, then one conditional subtract makes the value canonical.
    always_comb begin
        w_prod  = PW'(r_a) * PW'(r_b);
        w_fold1 = F1W'(w_prod[FE_BITS-1:0]) + F1W'(w_prod[PW-1:FE_BITS]) * F1W'(19);
        w_fold2 = F2W'(w_fold1[FE_BITS-1:0]) + F2W'(w_fold1[F1W-1:FE_BITS]) * F2W'(19);
        w_fold3 = w_fold2[FE_BITS-1:0] + (w_fold2[FE_BITS] ? FE_BITS'(19) : FE_BITS'(0));
        w_red   = (w_fold3 >= FE_P) ? (w_fold3 - FE_P) : w_fold3;
    end

    // Capture operands on start, publish the reduced product one cycle later.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_out  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_a    <= i_a;
                r_b    <= i_b;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
                r_out  <= w_red;
            end
        end
    end

    assign o_done = r_done;
    assign o_out  = r_out;

endmodule

// File: rtl/feinv.sv
// Fermat inverter: out = in^EXP mod p via left-to-right square-and-multiply,
// one femul transaction per step.
//
// state | meaning
// IDLE  | ready for a new operand
// ISSUE | femul start pulse for the current square or multiply
// WAIT  | femul busy; acc is replaced by the product on femul done
// FIN   | result presented on out, done pulse
module feinv
    import fe_pkg::*;
#(
    parameter int                  EXP_BITS = FE_BITS,
    parameter logic [EXP_BITS-1:0] EXP      = EXP_BITS'(FE_P_MINUS_2)
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [FE_BITS-1:0] i_in,
    output logic               o_ready,
    output logic               o_done,
    output logic [FE_BITS-1:0] o_out
);

    // Leading exponent bit is implied by loading acc with the operand.
    localparam logic [7:0] IDX_TOP = 8'(EXP_BITS - 2);

    feinv_state_t       r_state;
    feinv_op_t          r_op;
    logic [FE_BITS-1:0] r_acc;
    logic [FE_BITS-1:0] r_base;
    logic [FE_BITS-1:0] r_out;
    logic [7:0]         r_idx;

    feinv_state_t       w_state_nxt;
    feinv_op_t          w_op_nxt;
    logic [FE_BITS-1:0] w_acc_nxt;
    logic [FE_BITS-1:0] w_base_nxt;
    logic [FE_BITS-1:0] w_out_nxt;
    logic [7:0]         w_idx_nxt;

    logic               w_mul_start;
    logic               w_mul_done;
    logic [FE_BITS-1:0] w_mul_b;
    logic [FE_BITS-1:0] w_mul_out;

    assign w_mul_start = (r_state == ISSUE);
    assign w_mul_b     = (r_op == OP_SQR) ? r_acc : r_base;
    assign o_ready     = (r_state == IDLE);
    assign o_done      = (r_state == FIN);
    assign o_out       = r_out;

    femul u_femul (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_start (w_mul_start),
        .i_a     (r_acc),
        .i_b     (w_mul_b),
        .o_done  (w_mul_done),
        .o_out   (w_mul_out)
    );

    // Next-state and datapath updates; out is loaded on entry to FIN so it is
    // already valid in the done cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_acc_nxt   = r_acc;
        w_base_nxt  = r_base;
        w_out_nxt   = r_out;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_acc_nxt  = i_in;
                    w_base_nxt = i_in;
                    w_idx_nxt  = IDX_TOP;
                    w_op_nxt   = OP_SQR;
                    if (EXP_BITS == 1) begin
                        w_out_nxt   = i_in;
                        w_state_nxt = FIN;
                    end else begin
                        w_state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (w_mul_done) begin
                    w_acc_nxt = w_mul_out;
                    if ((r_op == OP_SQR) && EXP[r_idx]) begin
                        w_op_nxt    = OP_MUL;
                        w_state_nxt = ISSUE;
                    end else if (r_idx == 8'd0) begin
                        w_out_nxt   = w_mul_out;
                        w_state_nxt = FIN;
                    end else begin
                        w_idx_nxt   = r_idx - 8'd1;
                        w_op_nxt    = OP_SQR;
                        w_state_nxt = ISSUE;
                    end
                end
            end
            FIN: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_op    <= OP_SQR;
            r_acc   <= '0;
            r_base  <= '0;
            r_out   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_acc   <= w_acc_nxt;
            r_base  <= w_base_nxt;
            r_out   <= w_out_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

endmodule
